// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch stage and its neighbours.
package pipe_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam int unsigned PC_STEP  = 4;

endpackage

// File: rtl/fetch_if.sv
// Program-memory request/acknowledge bus between fetch (master) and imem (slave).
interface fetch_if #(
  parameter int unsigned DWIDTH = 32
);
  logic              imem_req;
  logic [DWIDTH-1:0] imem_addr;
  logic              imem_ack;
  logic [DWIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_pc.sv
// Program counter with sequential step, branch load and a pending-redirect register.
module fetch_pc
  import pipe_pkg::*;
#(
  parameter int unsigned       DWIDTH     = 32,
  parameter logic [DWIDTH-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_seq_i,
  input  logic              load_target_i,
  input  logic              load_redirect_i,
  input  logic              save_redirect_i,
  input  logic [DWIDTH-1:0] target_i,
  output logic [DWIDTH-1:0] pc_o
);

  logic [DWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] redirect_q, redirect_d;
  logic [DWIDTH-1:0] target_aligned;

  // Branch targets are word aligned; the low two bits are dropped.
  assign target_aligned = target_i & ~DWIDTH'(3);

  always_comb begin
    pc_d       = pc_q;
    redirect_d = redirect_q;
    if (save_redirect_i) redirect_d = target_aligned;
    if (load_target_i)        pc_d = target_aligned;
    else if (load_redirect_i) pc_d = redirect_q;
    else if (load_seq_i)      pc_d = pc_q + DWIDTH'(PC_STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_ADDR;
      redirect_q <= '0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: issues imem requests from the PC and owns the IF/ID register.
module fetch
  import pipe_pkg::*;
#(
  parameter int unsigned       DWIDTH     = 32,
  parameter logic [DWIDTH-1:0] RESET_ADDR = '0,
  parameter logic [DWIDTH-1:0] NOP        = DWIDTH'(NOP_INSN)
) (
  input  logic              clk,
  input  logic              rst,
  fetch_if.master           imem,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [DWIDTH-1:0] branch_target,
  output logic [DWIDTH-1:0] stored_addr,
  output logic [DWIDTH-1:0] stored_inst,
  output logic              stored_valid
);

  fetch_state_e state_q, state_d;

  logic [DWIDTH-1:0] stored_addr_q, stored_addr_d;
  logic [DWIDTH-1:0] stored_inst_q, stored_inst_d;
  logic              stored_valid_q, stored_valid_d;
  logic [DWIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [DWIDTH-1:0] hold_inst_q, hold_inst_d;

  logic              load_seq, load_target, load_redirect, save_redirect;
  logic [DWIDTH-1:0] pc;

  fetch_pc #(
    .DWIDTH     (DWIDTH),
    .RESET_ADDR (RESET_ADDR)
  ) u_pc (
    .clk             (clk),
    .rst             (rst),
    .load_seq_i      (load_seq),
    .load_target_i   (load_target),
    .load_redirect_i (load_redirect),
    .save_redirect_i (save_redirect),
    .target_i        (branch_target),
    .pc_o            (pc)
  );

  assign imem.imem_req  = (state_q != HOLD);
  assign imem.imem_addr = pc;

  // Next-state, PC control and IF/ID register update.
  always_comb begin
    state_d        = state_q;
    stored_addr_d  = stored_addr_q;
    stored_inst_d  = stored_inst_q;
    stored_valid_d = stored_valid_q;
    hold_addr_d    = hold_addr_q;
    hold_inst_d    = hold_inst_q;
    load_seq       = 1'b0;
    load_target    = 1'b0;
    load_redirect  = 1'b0;
    save_redirect  = 1'b0;

    // A taken branch flushes the presented instruction regardless of stall.
    if (branch_taken) begin
      stored_valid_d = 1'b0;
      stored_inst_d  = NOP;
    end

    case (state_q)
      FETCH: begin
        if (branch_taken) begin
          if (imem.imem_ack) begin
            load_target = 1'b1;
          end else begin
            save_redirect = 1'b1;
            state_d       = DRAIN;
          end
        end else if (imem.imem_ack) begin
          if (stall) begin
            hold_addr_d = pc;
            hold_inst_d = imem.imem_rdata;
            state_d     = HOLD;
          end else begin
            stored_addr_d  = pc;
            stored_inst_d  = imem.imem_rdata;
            stored_valid_d = 1'b1;
            load_seq       = 1'b1;
          end
        end else if (!stall) begin
          stored_valid_d = 1'b0;
          stored_inst_d  = NOP;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          hold_addr_d = '0;
          hold_inst_d = '0;
          load_target = 1'b1;
          state_d     = FETCH;
        end else if (!stall) begin
          stored_addr_d  = hold_addr_q;
          stored_inst_d  = hold_inst_q;
          stored_valid_d = 1'b1;
          hold_addr_d    = '0;
          hold_inst_d    = '0;
          load_seq       = 1'b1;
          state_d        = FETCH;
        end
      end

      DRAIN: begin
        // The outstanding response is dropped; the newest target wins.
        if (branch_taken) begin
          if (imem.imem_ack) begin
            load_target = 1'b1;
            state_d     = FETCH;
          end else begin
            save_redirect = 1'b1;
          end
        end else if (imem.imem_ack) begin
          load_redirect = 1'b1;
          state_d       = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FETCH;
      stored_addr_q  <= '0;
      stored_inst_q  <= NOP;
      stored_valid_q <= 1'b0;
      hold_addr_q    <= '0;
      hold_inst_q    <= '0;
    end else begin
      state_q        <= state_d;
      stored_addr_q  <= stored_addr_d;
      stored_inst_q  <= stored_inst_d;
      stored_valid_q <= stored_valid_d;
      hold_addr_q    <= hold_addr_d;
      hold_inst_q    <= hold_inst_d;
    end
  end

  assign stored_addr  = stored_addr_q;
  assign stored_inst  = stored_inst_q;
  assign stored_valid = stored_valid_q;

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch against a behavioural model, plus a wrap-around instance.
module tb_fetch;

  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] stored_addr, stored_inst;
  logic        stored_valid;
  logic [31:0] w_addr, w_inst;
  logic        w_valid;

  fetch_if #(.DWIDTH(32)) mif ();
  fetch_if #(.DWIDTH(32)) wif ();

  fetch #(.DWIDTH(32), .RESET_ADDR(32'h0)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (mif.master),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stored_addr   (stored_addr),
    .stored_inst   (stored_inst),
    .stored_valid  (stored_valid)
  );

  fetch #(.DWIDTH(32), .RESET_ADDR(32'hFFFF_FFF8)) u_wrap (
    .clk           (clk),
    .rst           (rst),
    .imem          (wif.master),
    .stall         (1'b0),
    .branch_taken  (1'b0),
    .branch_target (32'h0),
    .stored_addr   (w_addr),
    .stored_inst   (w_inst),
    .stored_valid  (w_valid)
  );

  // Zero-wait memory for the wrap instance.
  assign wif.imem_ack   = wif.imem_req;
  assign wif.imem_rdata = ~wif.imem_addr;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model of what the stage must present.
  logic [31:0] m_pc;
  logic        m_draining;
  logic [31:0] m_redirect;
  logic        m_held;
  logic [31:0] m_held_addr, m_held_inst;
  logic [31:0] m_sa, m_si;
  logic        m_sv;
  int          wait_left;
  logic        prev_br;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input logic [31:0] reset_pc);
    m_pc = reset_pc; m_draining = 1'b0; m_redirect = '0;
    m_held = 1'b0; m_held_addr = '0; m_held_inst = '0;
    m_sa = '0; m_si = NOPW; m_sv = 1'b0;
    wait_left = 0; prev_br = 1'b0;
  endtask

  task automatic compare_all();
    check("imem_req",     {31'd0, mif.imem_req}, {31'd0, !m_held});
    check("imem_addr",    mif.imem_addr, m_pc);
    check("stored_addr",  stored_addr, m_sa);
    check("stored_inst",  stored_inst, m_si);
    check("stored_valid", {31'd0, stored_valid}, {31'd0, m_sv});
  endtask

  task automatic model_step(input logic st, input logic br, input logic [31:0] tgt,
                            input logic ack, input logic [31:0] rd);
    logic [31:0] t;
    t = {tgt[31:2], 2'b00};
    if (br) begin
      m_sv = 1'b0; m_si = NOPW;
      if (m_held) begin
        m_held = 1'b0; m_pc = t;
      end else if (ack) begin
        m_draining = 1'b0; m_pc = t;
      end else begin
        m_draining = 1'b1; m_redirect = t;
      end
    end else if (m_held) begin
      if (!st) begin
        m_sa = m_held_addr; m_si = m_held_inst; m_sv = 1'b1;
        m_pc = m_pc + 32'd4; m_held = 1'b0;
      end
    end else if (m_draining) begin
      if (ack) begin m_pc = m_redirect; m_draining = 1'b0; end
    end else if (ack && !st) begin
      m_sa = m_pc; m_si = rd; m_sv = 1'b1; m_pc = m_pc + 32'd4;
    end else if (ack) begin
      m_held = 1'b1; m_held_addr = m_pc; m_held_inst = rd;
    end else if (!st) begin
      m_sv = 1'b0; m_si = NOPW;
    end
  endtask

  // One cycle: compare, choose inputs and memory response, advance model, wait for next negedge.
  task automatic run_cycles(input int n, input int directed);
    logic        st, br, ack;
    logic [31:0] tgt, rd;
    for (int cyc = 0; cyc < n; cyc++) begin
      compare_all();
      if (cyc < directed) begin
        st = 1'b0; br = 1'b0; tgt = '0;
      end else begin
        st  = ($urandom_range(0, 3) == 0);
        br  = !prev_br && ($urandom_range(0, 9) == 0);
        tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : 32'($urandom);
      end
      prev_br = br;
      ack = 1'b0;
      rd  = 32'($urandom);
      if (!m_held) begin
        if (wait_left == 0) begin
          ack = 1'b1;
          rd  = mem_word(m_pc);
          wait_left = (cyc < directed) ? 0 : $urandom_range(0, 2);
        end else begin
          wait_left--;
        end
      end
      stall = st; branch_taken = br; branch_target = tgt;
      mif.imem_ack = ack; mif.imem_rdata = rd;
      model_step(st, br, tgt, ack, rd);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    mif.imem_ack = 1'b0; mif.imem_rdata = '0;
    model_reset(32'h0);
    repeat (2) @(negedge clk);

    // Reset values, literal.
    check("rst_valid",     {31'd0, stored_valid}, 32'd0);
    check("rst_inst",      stored_inst, NOPW);
    check("rst_addr",      stored_addr, 32'd0);
    check("rst_req",       {31'd0, mif.imem_req}, 32'd1);
    check("rst_imem_addr", mif.imem_addr, 32'd0);
    check("rst_wrap_addr", wif.imem_addr, 32'hFFFF_FFF8);
    rst = 1'b0;

    // Zero-wait, no stall: hand-computed sequence for both instances.
    run_cycles(1, 4);
    check("seq0_addr",  stored_addr, 32'd0);
    check("seq0_valid", {31'd0, stored_valid}, 32'd1);
    check("wrap0_addr", w_addr, 32'hFFFF_FFF8);
    check("wrap0_inst", w_inst, 32'h0000_0007);
    run_cycles(1, 3);
    check("seq1_addr",  stored_addr, 32'd4);
    check("wrap1_addr", w_addr, 32'hFFFF_FFFC);
    run_cycles(1, 2);
    check("seq2_addr",  stored_addr, 32'd8);
    check("wrap2_addr", w_addr, 32'h0000_0000);
    check("wrap2_next", wif.imem_addr, 32'h0000_0004);
    run_cycles(1, 1);
    check("seq3_addr",  stored_addr, 32'd12);
    check("seq3_inst",  stored_inst, mem_word(32'd12));

    // Randomized traffic against the model.
    run_cycles(3000, 0);

    // Asynchronous reset mid-stream: reset values must appear before the next edge.
    #2 rst = 1'b1;
    #1;
    check("arst_valid",     {31'd0, stored_valid}, 32'd0);
    check("arst_inst",      stored_inst, NOPW);
    check("arst_addr",      stored_addr, 32'd0);
    check("arst_imem_addr", mif.imem_addr, 32'd0);
    check("arst_req",       {31'd0, mif.imem_req}, 32'd1);
    check("arst_wrap_addr", wif.imem_addr, 32'hFFFF_FFF8);
    stall = 1'b0; branch_taken = 1'b0; mif.imem_ack = 1'b0;
    model_reset(32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_cycles(500, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
